// File: rtl/spi_master_sched_pkg.sv
// Shared types and helpers for the SPI master scheduler.
// Holds the FSM state encoding, the default frame width and clog2.
package spi_master_sched_pkg;

    localparam int DW_DEF = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_WAIT,
        S_CAPT,
        S_GAP
    } state_e;

    // Never returns 0 so that it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/spi_master_sched_rr_arbiter.sv
// Combinational round-robin selector: first asserted req at or after ptr,
// wrapping from N-1 to 0. Emits a one-hot grant and the winner index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin : sel
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_master_sched.sv
// Round-robin scheduler sharing one SPI master among N_REQ requesters,
// with a per-frame timeout and a minimum inter-frame gap.
module spi_master_sched
    import spi_master_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DW_DEF,
    parameter int GAP   = 8,
    parameter int TMO   = 4096
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_dat,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       rsp_dat,
    output logic                err,
    output logic                busy,
    output logic                st,
    output logic [DW-1:0]       MTX_DAT,
    input  logic [DW-1:0]       MRX_DAT,
    input  logic                end_TX
);

    localparam int IW = clog2(N_REQ);
    localparam int TW = clog2(TMO);
    localparam int GW = clog2(GAP + 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [DW-1:0]    mtx_q, mtx_d;
    logic [DW-1:0]    rsp_q, rsp_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             tmo_q, tmo_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            mtx_q   <= '0;
            rsp_q   <= '0;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            mtx_q   <= mtx_d;
            rsp_q   <= rsp_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        mtx_d   = mtx_q;
        rsp_d   = rsp_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) state_d = S_ARB;
            end
            S_ARB: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    mtx_d   = req_dat[arb_idx*DW +: DW];
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real end-of-frame beats a coincident timeout.
                if (end_TX) begin
                    rsp_d   = MRX_DAT;
                    tmo_d   = 1'b0;
                    state_d = S_CAPT;
                end else if (tcnt_q == TW'(TMO - 1)) begin
                    rsp_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = S_CAPT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_CAPT: begin
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                gnt_d   = '0;
                gcnt_d  = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gcnt_q == GW'(GAP - 1)) begin
                    state_d = (|req) ? S_ARB : S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign st      = (state_q == S_START);
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_CAPT) ? gnt_q : '0;
    assign err     = (state_q == S_CAPT) && tmo_q;
    assign gnt     = gnt_q;
    assign rsp_dat = rsp_q;
    assign MTX_DAT = mtx_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched: a table of transactions with
// hand-computed results, plus reset and request-drop sequences.
module tb_spi_master_sched;

    localparam int N   = 4;
    localparam int DW  = 11;
    localparam int GP  = 8;
    localparam int TM  = 64;

    localparam logic [DW-1:0] S0 = 11'b01100100100;
    localparam logic [DW-1:0] S1 = 11'h2A5;
    localparam logic [DW-1:0] S2 = 11'h15A;
    localparam logic [DW-1:0] S3 = 11'h7F0;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rsp_dat, MTX_DAT;
    logic [DW-1:0]   MRX_DAT = '0;
    logic            err, busy, st;
    logic            end_TX = 1'b0;

    assign req_dat = {S3, S2, S1, S0};

    spi_master_sched #(
        .N_REQ (N),
        .DW    (DW),
        .GAP   (GP),
        .TMO   (TM)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .req     (req),
        .req_dat (req_dat),
        .gnt     (gnt),
        .done    (done),
        .rsp_dat (rsp_dat),
        .err     (err),
        .busy    (busy),
        .st      (st),
        .MTX_DAT (MTX_DAT),
        .MRX_DAT (MRX_DAT),
        .end_TX  (end_TX)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  req;
        int            end_dly;
        logic [DW-1:0] rx;
        logic          drop;
        logic [N-1:0]  req_after;
        int            exp_lat;
        logic [N-1:0]  exp_gnt;
        logic [DW-1:0] exp_mtx;
        logic          exp_err;
        logic [DW-1:0] exp_rsp;
    } vec_t;

    vec_t vecs[15];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t mk(
        input logic [N-1:0] rq, input int dly, input logic [DW-1:0] rx,
        input logic drp, input logic [N-1:0] ra, input int lat,
        input logic [N-1:0] eg, input logic [DW-1:0] em,
        input logic ee, input logic [DW-1:0] er);
        vec_t v;
        v.req = rq; v.end_dly = dly; v.rx = rx; v.drop = drp;
        v.req_after = ra; v.exp_lat = lat; v.exp_gnt = eg;
        v.exp_mtx = em; v.exp_err = ee; v.exp_rsp = er;
        return v;
    endfunction

    task automatic check(input string name, input int id,
                         input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    task automatic wait_idle(input int id);
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("idle", id, busy, 0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int k;
        if (v.exp_lat == 2) wait_idle(id);
        req = v.req;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!st && k < 50);
        check("st_lat", id, k, v.exp_lat);
        check("mtx", id, MTX_DAT, v.exp_mtx);
        check("gnt", id, gnt, v.exp_gnt);
        if (v.drop) req = '0;
        if (v.end_dly > 0) begin
            repeat (v.end_dly) @(negedge clk);
            end_TX  = 1'b1;
            MRX_DAT = v.rx;
            @(negedge clk);
            end_TX  = 1'b0;
            MRX_DAT = '0;
        end else begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (done == '0 && k < 200);
            check("tmo_lat", id, k, TM + 1);
        end
        check("done", id, done, v.exp_gnt);
        check("err", id, err, v.exp_err);
        check("rsp", id, rsp_dat, v.exp_rsp);
        req = v.req_after;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   k;
        int   nst;
        int   nbusy;
        vec_t vx;

        // All four requesting continuously: strict rotation 0,1,2,3,...
        vecs[0]  = mk(4'b1111, 5,  11'h58D, 0, 4'b1111, 2,  4'b0001, S0, 0, 11'h58D);
        vecs[1]  = mk(4'b1111, 1,  11'h0F1, 0, 4'b1111, 10, 4'b0010, S1, 0, 11'h0F1);
        vecs[2]  = mk(4'b1111, 3,  11'h3C3, 0, 4'b1111, 10, 4'b0100, S2, 0, 11'h3C3);
        vecs[3]  = mk(4'b1111, 7,  11'h6AA, 0, 4'b1111, 10, 4'b1000, S3, 0, 11'h6AA);
        vecs[4]  = mk(4'b1111, 2,  11'h111, 0, 4'b1111, 10, 4'b0001, S0, 0, 11'h111);
        vecs[5]  = mk(4'b1111, 10, 11'h222, 0, 4'b1111, 10, 4'b0010, S1, 0, 11'h222);
        vecs[6]  = mk(4'b1111, 4,  11'h444, 0, 4'b1111, 10, 4'b0100, S2, 0, 11'h444);
        vecs[7]  = mk(4'b1111, 6,  11'h7FF, 0, 4'b0000, 10, 4'b1000, S3, 0, 11'h7FF);
        // Single request from idle with the reference words.
        vecs[8]  = mk(4'b0001, 5,  11'b10110001101, 0, 4'b0000, 2, 4'b0001, S0, 0, 11'b10110001101);
        // ptr=1 skips to 2; then ptr=3 wraps to 0.
        vecs[9]  = mk(4'b0101, 3,  11'h1CE, 0, 4'b0101, 2,  4'b0100, S2, 0, 11'h1CE);
        vecs[10] = mk(4'b0101, 1,  11'h2DF, 0, 4'b0000, 10, 4'b0001, S0, 0, 11'h2DF);
        // Timeout on requester 3, then requester 1 is served.
        vecs[11] = mk(4'b1000, 0,  11'h000, 0, 4'b0010, 2,  4'b1000, S3, 1, 11'h000);
        vecs[12] = mk(4'b0010, 8,  11'h3E0, 0, 4'b0000, 10, 4'b0010, S1, 0, 11'h3E0);
        // end_TX on the timeout terminal cycle.
        vecs[13] = mk(4'b0100, TM, 11'h5A5, 0, 4'b0000, 2,  4'b0100, S2, 0, 11'h5A5);
        // req dropped right after st; done still expected.
        vecs[14] = mk(4'b0100, 4,  11'h0F0, 1, 4'b0000, 2,  4'b0100, S2, 0, 11'h0F0);

        repeat (3) @(negedge clk);
        check("reset_outs", -1,
              {st, gnt, done, err, busy, rsp_dat, MTX_DAT}, 0);
        clr_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        // Request gone by the ARB cycle: back to idle, no start pulse.
        wait_idle(100);
        req = 4'b0001;
        @(negedge clk);
        check("arb_busy", 100, busy, 1);
        req = '0;
        nst = 0;
        repeat (10) begin
            @(negedge clk);
            if (st) nst++;
        end
        check("arb_no_st", 100, nst, 0);
        check("arb_idle", 100, {busy, gnt}, 0);

        // Reset while waiting for end_TX.
        wait_idle(101);
        req = 4'b0010;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!st && k < 50);
        check("rst_st_lat", 101, k, 2);
        @(negedge clk);
        check("rst_pre", 101, {busy, gnt}, {1'b1, 4'b0010});
        clr_n = 1'b0;
        #1;
        check("rst_async", 101,
              {st, gnt, done, err, busy, rsp_dat, MTX_DAT}, 0);
        @(negedge clk);
        clr_n   = 1'b1;
        req     = '0;
        end_TX  = 1'b1;
        MRX_DAT = 11'h7FF;
        @(negedge clk);
        end_TX  = 1'b0;
        MRX_DAT = '0;
        nst = 0;
        nbusy = 0;
        repeat (10) begin
            @(negedge clk);
            if (done != '0 || err || st) nst++;
            if (busy) nbusy++;
        end
        check("rst_no_done", 101, nst, 0);
        check("rst_no_busy", 101, nbusy, 0);
        check("rst_rsp", 101, rsp_dat, 0);

        // Pointer restarts at 0 after reset.
        vx = mk(4'b1111, 2, 11'h155, 0, 4'b0000, 2, 4'b0001, S0, 0, 11'h155);
        run_vec(102, vx);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/spi_master_sched.md
SPI_MASTER_SCHED -- requirements
Module: spi_master_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning number of requesters sharing one SPI master.
REQ-002 The block SHALL have parameter DW, default 11, meaning SPI frame width in bits.
REQ-003 The block SHALL have parameter GAP, default 8, meaning the minimum number of clk cycles between end_TX and the next st.
REQ-004 The block SHALL have parameter TMO, default 4096, meaning the number of clk cycles to wait for end_TX before abort.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port clr_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, N_REQ bits: per-requester transaction request, level.
REQ-008 The block SHALL have port req_dat, input, N_REQ*DW bits: per-requester TX word; slice i is [i*DW +: DW].
REQ-009 The block SHALL have port gnt, output, N_REQ bits: one-hot grant, held for the whole transaction.
REQ-010 The block SHALL have port done, output, N_REQ bits: one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port rsp_dat, output, DW bits: received word, valid in the done cycle and held until the next capture.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle timeout pulse, coincident with done.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port st, output, 1 bit: one-cycle start pulse to the SPI master.
REQ-015 The block SHALL have port MTX_DAT, output, DW bits: TX word to the SPI master, stable from st until end_TX.
REQ-016 The block SHALL have port MRX_DAT, input, DW bits: RX word from the SPI master, valid when end_TX is high.
REQ-017 The block SHALL have port end_TX, input, 1 bit: SPI master end-of-frame strobe.

Function
REQ-018 The FSM SHALL have the states IDLE, ARB, START, WAIT, CAPT and GAP.
REQ-019 IDLE SHALL go to ARB on the cycle after any bit of req is high.
REQ-020 ARB SHALL select, in one cycle, the first asserted req at or after pointer ptr, wrapping from N_REQ-1 to 0, then set gnt and latch MTX_DAT from the winner's slice.
REQ-021 ARB SHALL return to IDLE if req has dropped to 0 by the ARB cycle.
REQ-022 START SHALL assert st for exactly one cycle, load the timeout counter with 0, and go to WAIT.
REQ-023 WAIT SHALL go to CAPT on end_TX=1, and on the cycle the counter reaches TMO-1 SHALL go to CAPT with the timeout flag set.
REQ-024 CAPT SHALL pulse done[winner] for one cycle.
REQ-025 In CAPT, rsp_dat SHALL become MRX_DAT on a normal end, or 0 with err=1 on timeout.
REQ-026 In CAPT, ptr SHALL become winner+1 modulo N_REQ.
REQ-027 GAP SHALL count GAP cycles with gnt cleared, then go to ARB if any req is high, else to IDLE.
REQ-028 Latency SHALL be st exactly 2 cycles after req rises from IDLE, and done exactly 1 cycle after end_TX.
REQ-029 Dropping req mid-transaction SHALL NOT abort the transaction; done is still issued.
REQ-030 An end_TX outside WAIT SHALL be ignored.
REQ-031 If end_TX and timeout occur in the same cycle, end_TX SHALL win and err stays 0.
REQ-032 With all N_REQ requesting continuously, grants SHALL rotate 0,1,2,3,0,...; no requester waits more than N_REQ-1 transactions.
REQ-033 Counter widths SHALL be clog2(TMO) and clog2(GAP+1), with no wrap before the terminal count.

Reset
REQ-034 clr_n=0 SHALL, asynchronously, force state to IDLE and set st, gnt, done, err, busy to 0, rsp_dat and MTX_DAT to 0, and ptr to 0.
REQ-035 Reset mid-transaction SHALL produce no done pulse; after release the FSM starts from IDLE, and a late end_TX is ignored.
REQ-036 Reset release SHALL take effect on the first clk edge with clr_n=1.

Structure
REQ-037 A shared package SHALL hold the state enumeration, default DW=11, and the clog2 helper function.
REQ-038 The round-robin selector SHALL be one sub-module, rr_arbiter (inputs req and ptr; outputs one-hot grant and index), combinational and reusable by other codebase blocks; the FSM and counters stay in spi_master_sched.

Verification
REQ-039 Scenario single request: req=0001, slice0=11'b01100100100, SPI model returns 11'b10110001101 -> st 2 cycles after req, MTX_DAT=11'b01100100100, done[0] 1 cycle after end_TX, rsp_dat=11'b10110001101, err=0.
REQ-040 Scenario all requesting: req=1111 held for 8 frames -> gnt order 0,1,2,3,0,1,2,3, and at least GAP cycles between each end_TX and the next st.
REQ-041 Scenario timeout: SPI model never asserts end_TX, TMO=64 -> err and done[winner] 64 cycles after the WAIT entry, rsp_dat=0, and the next requester is served.
REQ-042 Scenario reset during WAIT: clr_n=0 for 1 cycle -> all outputs 0 immediately, no done, and a late end_TX is ignored.
REQ-043 Scenario simultaneous events: end_TX lands on the timeout terminal cycle -> err=0 and rsp_dat=MRX_DAT.
REQ-044 Scenario req drop: req[2] is deasserted after st -> done[2] still pulses, and ARB with req=0 returns to IDLE with no st.
